dfa_stream_ctx_mgr: RTL and testbench

- Parametrised per-stream context manager for one regex DFA core in the packet-inspection datapath.
- Saves and restores DFA state per stream ID across packets, so a match can span packet boundaries.
- Accumulates a speculative per-packet match flag and commits it to a saturating match count at end of packet.
- Generalises the fixed 64-stream, 11-bit-state wrapper:
  - exposes the DFA through ports, so any DFA core can be attached;
  - adds a drain FSM, a ready handshake, per-slot valid bits and protocol error flagging.

---
 rtl/dfa_stream_ctx_mgr.sv | 205 ++++++++++++++++++++
 tb/tb_dfa_stream_ctx_mgr.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfa_stream_ctx_mgr.sv
// dfa_stream_ctx_mgr: per-stream context manager wrapped around an external
// regex DFA core. Restores the DFA state of a stream at packet start, feeds
// payload bytes to the core, and at end of packet commits the match flag to a
// saturating global counter and saves the final DFA state back per stream.
// Optional build macro STREAM_HIT_CNT_EN adds a 16-bit saturating hit counter
// per slot, read through rd_sid/rd_hits with one cycle of latency.
//
// Handshake: ready=1 means a pkt_start (in IDLE) or a payload byte with
// char_in_vld (in RUN) is consumed on the next rising clock edge; anything
// presented while ready=0, or out of sequence, is dropped and sets the sticky
// protocol_err flag.
module dfa_stream_ctx_mgr #(
    parameter int STATE_W = 11,
    parameter int SID_W   = 6,
    parameter int COUNT_W = 16,
    parameter int DFA_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_start,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               enable,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               eop,
    output logic               ready,
    output logic               fired,
    output logic               match_done,
    output logic [COUNT_W-1:0] count,
    output logic               protocol_err,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [15:0]        rd_hits,
    output logic [2:0]         fsm_state
);

    localparam int NSLOT     = 2 ** SID_W;
    localparam int DRAIN_CYC = DFA_LAT + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t               state;
    logic [SID_W-1:0]     sid_q;
    logic                 en_q;
    logic [2:0]           drain_cnt;
    logic [NSLOT-1:0]     slot_vld;
    logic [STATE_W-1:0]   mem [NSLOT];
    logic [STATE_W-1:0]   state_q;
    logic                 accept_q;
    logic [DFA_LAT:0]     vld_pipe;
    logic                 acc_hit;
    logic                 bad_seq;
    logic                 commit_we;

    assign fsm_state = state;

    // An accept only counts when it belongs to a byte we fed; this masks the
    // stale accept of whatever state the core held before the restore.
    assign acc_hit = accept_q & vld_pipe[DFA_LAT];

    assign bad_seq = (pkt_start && state != S_IDLE)
                   || ((char_in_vld || eop) && state == S_IDLE)
                   || (char_in_vld && !ready);

    assign commit_we = (state == S_COMMIT) && en_q;

    // Register the core outputs and track which cycles carry a fed byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '0;
            accept_q <= 1'b0;
            vld_pipe <= '0;
        end else begin
            state_q  <= dfa_state_out;
            accept_q <= dfa_accept;
            vld_pipe <= {vld_pipe[DFA_LAT-1:0], dfa_char_vld};
        end
    end

    // Packet sequencing FSM with all control outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            sid_q            <= '0;
            en_q             <= 1'b0;
            drain_cnt        <= '0;
            slot_vld         <= '0;
            ready            <= 1'b0;
            fired            <= 1'b0;
            match_done       <= 1'b0;
            count            <= '0;
            protocol_err     <= 1'b0;
            dfa_char         <= '0;
            dfa_char_vld     <= 1'b0;
            dfa_state_in     <= '0;
            dfa_state_in_vld <= 1'b0;
        end else begin
            dfa_char_vld     <= 1'b0;
            dfa_state_in_vld <= 1'b0;
            match_done       <= 1'b0;
            if (bad_seq) begin
                protocol_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    ready <= 1'b1;
                    if (pkt_start) begin
                        state            <= S_LOAD;
                        ready            <= 1'b0;
                        sid_q            <= stream_id;
                        en_q             <= enable;
                        fired            <= 1'b0;
                        dfa_state_in     <= (new_stream_id || !slot_vld[stream_id])
                                            ? '0 : mem[stream_id];
                        dfa_state_in_vld <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_RUN;
                    ready <= 1'b1;
                end
                S_RUN: begin
                    fired <= fired | acc_hit;
                    if (char_in_vld) begin
                        dfa_char     <= char_in;
                        dfa_char_vld <= 1'b1;
                    end
                    if (eop) begin
                        state     <= S_DRAIN;
                        ready     <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    fired <= fired | acc_hit;
                    if (drain_cnt == 3'(DRAIN_CYC - 1)) begin
                        state      <= S_COMMIT;
                        match_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                S_COMMIT: begin
                    if (en_q) begin
                        if (fired && count != {COUNT_W{1'b1}}) begin
                            count <= count + COUNT_W'(1);
                        end
                        slot_vld[sid_q] <= 1'b1;
                    end else begin
                        fired <= 1'b0;
                    end
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Save the final DFA state of an enabled stream; contents are not reset.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            mem[sid_q] <= state_q;
        end
    end

`ifdef STREAM_HIT_CNT_EN
    logic [15:0] hits [NSLOT];

    // Per-slot saturating hit counters and their registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                hits[i] <= '0;
            end
            rd_hits <= '0;
        end else begin
            if (commit_we && fired && hits[sid_q] != 16'hFFFF) begin
                hits[sid_q] <= hits[sid_q] + 16'd1;
            end
            rd_hits <= hits[rd_sid];
        end
    end
`else
    logic unused_rd_sid;
    assign unused_rd_sid = ^rd_sid;
    assign rd_hits       = '0;
`endif

endmodule

// File: tb/tb_dfa_stream_ctx_mgr.sv
// Bench for dfa_stream_ctx_mgr: attaches a small "abc" recognising DFA core and
// checks packets against a text-level model that keeps the last three stream
// characters per slot.
module tb_dfa_stream_ctx_mgr;

  localparam int STATE_W = 11;
  localparam int SID_W   = 6;
  localparam int COUNT_W = 4;
  localparam int DFA_LAT = 1;
  localparam int NSLOT   = 64;
  localparam logic [23:0] PAT = "abc";

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               pkt_start = 1'b0;
  logic [SID_W-1:0]   stream_id = '0;
  logic               new_stream_id = 1'b0;
  logic               enable = 1'b0;
  logic [7:0]         char_in = '0;
  logic               char_in_vld = 1'b0;
  logic               eop = 1'b0;
  logic               ready, fired, match_done, protocol_err;
  logic [COUNT_W-1:0] count;
  logic [7:0]         dfa_char;
  logic               dfa_char_vld;
  logic [STATE_W-1:0] dfa_state_in;
  logic               dfa_state_in_vld;
  logic [STATE_W-1:0] dfa_state_out;
  logic               dfa_accept;
  logic [SID_W-1:0]   rd_sid = '0;
  logic [15:0]        rd_hits;
  logic [2:0]         fsm_state;

  dfa_stream_ctx_mgr #(
    .STATE_W(STATE_W), .SID_W(SID_W), .COUNT_W(COUNT_W), .DFA_LAT(DFA_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .stream_id(stream_id),
    .new_stream_id(new_stream_id), .enable(enable), .char_in(char_in),
    .char_in_vld(char_in_vld), .eop(eop), .ready(ready), .fired(fired),
    .match_done(match_done), .count(count), .protocol_err(protocol_err),
    .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
    .dfa_state_in(dfa_state_in), .dfa_state_in_vld(dfa_state_in_vld),
    .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept),
    .rd_sid(rd_sid), .rd_hits(rd_hits), .fsm_state(fsm_state)
  );

  // ---------------- attached DFA core ("abc", latency 1) ----------------
  logic [STATE_W-1:0] core_st = '0;

  function automatic logic [STATE_W-1:0] dfa_next(input logic [STATE_W-1:0] s,
                                                  input logic [7:0] c);
    if (c == 8'h61) return STATE_W'(1);
    if (s == STATE_W'(1) && c == 8'h62) return STATE_W'(2);
    if (s == STATE_W'(2) && c == 8'h63) return STATE_W'(3);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (dfa_state_in_vld) core_st <= dfa_state_in;
    else if (dfa_char_vld) core_st <= dfa_next(core_st, dfa_char);
  end
  assign dfa_state_out = core_st;
  assign dfa_accept    = (core_st == STATE_W'(3));

  // ---------------- reference model ----------------
  logic [23:0] m_hist [NSLOT];
  bit          m_vld  [NSLOT];
  int          m_hits [NSLOT];
  int          m_count;
  bit          m_perr;
  logic [7:0]  payload [$];

  function automatic int tail_state(input logic [23:0] h);
    if (h == PAT) return 3;
    if (h[15:0] == PAT[23:8]) return 2;
    if (h[7:0] == PAT[23:16]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) begin
      m_hist[i] = '0; m_vld[i] = 1'b0; m_hits[i] = 0;
    end
    m_count = 0;
    m_perr  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_payload(input string s);
    payload.delete();
    for (int i = 0; i < s.len(); i++) payload.push_back(s[i]);
  endtask

  task automatic run_packet(input int sid, input bit is_new, input bit en,
                            input bit eop_sep, input bit err_mid, input bit err_eop_start);
    logic [23:0] h;
    bit exp_fired;
    int exp_state;
    int lat;
    bit seen;
    exp_fired = 1'b0;
    h = (is_new || !m_vld[sid]) ? 24'h0 : m_hist[sid];
    exp_state = tail_state(h);
    foreach (payload[i]) begin
      h = {h[15:0], payload[i]};
      if (h == PAT) exp_fired = 1'b1;
    end

    @(negedge clk);
    check("ready_idle", ready, 1);
    pkt_start = 1'b1; stream_id = SID_W'(sid); new_stream_id = is_new; enable = en;
    eop = err_eop_start;
    if (err_eop_start) m_perr = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0; eop = 1'b0;
    stream_id = SID_W'($urandom); new_stream_id = 1'($urandom); enable = 1'($urandom);
    check("load_vld", dfa_state_in_vld, 1);
    check("load_state", dfa_state_in, exp_state);
    check("ready_load", ready, 0);

    for (int i = 0; i < payload.size(); i++) begin
      @(negedge clk);
      char_in_vld = 1'b0; pkt_start = 1'b0;
      if (i == 0) check("ready_run", ready, 1);
      while ($urandom_range(0, 3) == 0) @(negedge clk);
      char_in = payload[i];
      char_in_vld = 1'b1;
      eop = (i == payload.size() - 1) && !eop_sep;
      if (err_mid && i == 0) begin
        pkt_start = 1'b1;
        m_perr = 1'b1;
      end
    end
    @(negedge clk);
    char_in_vld = 1'b0; pkt_start = 1'b0;
    if (payload.size() == 0 || eop_sep) begin
      eop = 1'b1;
      @(negedge clk);
    end
    eop = 1'b0;

    check("ready_drain", ready, 0);
    lat = 1; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (match_done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("done_seen", seen, 1);
    check("done_lat", lat, DFA_LAT + 3);
    check("fired_commit", fired, exp_fired);
    check("ready_commit", ready, 0);

    if (en) begin
      m_hist[sid] = h;
      m_vld[sid]  = 1'b1;
      if (exp_fired && m_count < (1 << COUNT_W) - 1) m_count++;
      if (exp_fired && m_hits[sid] < 65535) m_hits[sid]++;
    end

    @(negedge clk);
    check("done_pulse", match_done, 0);
    check("count", count, m_count);
    check("fired_after", fired, en ? exp_fired : 1'b0);
    check("ready_after", ready, 1);
    check("perr", protocol_err, m_perr);
  endtask

  task automatic check_hits(input int sid);
    int exp;
    @(negedge clk);
    rd_sid = SID_W'(sid);
    @(negedge clk);
`ifdef STREAM_HIT_CNT_EN
    exp = m_hits[sid];
`else
    exp = 0;
`endif
    check("rd_hits", rd_hits, exp);
  endtask

  // ---------------- stimulus ----------------
  int sids [6] = '{0, 1, 2, 5, 9, 63};
  string alpha = "abcx";

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_count", count, 0);
    check("rst_fired", fired, 0);
    check("rst_done", match_done, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_ldvld", dfa_state_in_vld, 0);
    check("rst_chvld", dfa_char_vld, 0);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_post_rst", ready, 1);
    check_hits(5);

    // new stream, match inside one packet
    set_payload("abc"); run_packet(5, 1, 1, 0, 0, 0);
    // resume mid-pattern across packets
    set_payload("ab");  run_packet(5, 0, 1, 0, 0, 0);
    set_payload("c");   run_packet(5, 0, 1, 1, 0, 0);
    // disabled regex: fires but nothing committed
    set_payload("abc"); run_packet(7, 1, 0, 0, 0, 0);
    set_payload("c");   run_packet(7, 0, 1, 0, 0, 0);
    // zero-byte packets write the restored state back unchanged
    set_payload("abc"); run_packet(9, 1, 1, 0, 0, 0);
    set_payload("");    run_packet(9, 0, 1, 0, 0, 0);
    set_payload("");    run_packet(9, 0, 1, 0, 0, 0);

    // protocol errors
    set_payload("xab"); run_packet(3, 1, 1, 0, 1, 0);
    @(negedge clk);
    char_in = 8'h63; char_in_vld = 1'b1;
    @(negedge clk);
    char_in_vld = 1'b0;
    m_perr = 1'b1;
    check("perr_idle_char", protocol_err, 1);
    check("idle_char_dropped", dfa_char_vld, 0);
    check("idle_state", fsm_state, 0);
    check("idle_count", count, m_count);
    set_payload("c");   run_packet(3, 0, 1, 0, 0, 1);

    // randomized traffic
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(0, 6);
      payload.delete();
      for (int i = 0; i < len; i++) payload.push_back(alpha[$urandom_range(0, 3)]);
      run_packet(sids[$urandom_range(0, 5)], $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 1), 0, 0);
    end

    // reset in the middle of a packet discards it
    @(negedge clk);
    pkt_start = 1'b1; stream_id = SID_W'(5); new_stream_id = 1'b0; enable = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    @(negedge clk);
    char_in = 8'h61; char_in_vld = 1'b1;
    @(negedge clk);
    char_in_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_perr", protocol_err, 0);
    rst_n = 1'b1;
    model_reset();
    set_payload("bc"); run_packet(5, 0, 1, 0, 0, 0);

    // per-stream hit counters
    set_payload("abc");
    run_packet(2, 1, 1, 0, 0, 0);
    run_packet(2, 1, 1, 0, 0, 0);
    run_packet(2, 1, 1, 0, 0, 0);
    run_packet(9, 1, 1, 0, 0, 0);
    check_hits(2);
    check_hits(9);
    check_hits(11);

    // saturation of the global counter
    for (int p = 0; p < 14; p++) run_packet(10, 1, 1, 0, 0, 0);
    check("count_sat", count, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
